// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage drives the master side; the memory model drives the slave side.
interface fetch_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] rdata;
    logic               ready;

    modport master (output req, output addr, input rdata, input ready);
    modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, variable-latency imem and branch redirect.
// Optional FETCH_PERF_CNT_EN adds a stall_cycles counter of bubbles caused by waits/redirects.
module fetch_stage #(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    fetch_stage_if.master      imem,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    typedef enum logic {FETCH, REDIRECT} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc, pc_nxt;
    logic [ADDR_W-1:0]  redirect_addr, redirect_addr_nxt;
    logic [ADDR_W-1:0]  pc_out_nxt;
    logic [INSTR_W-1:0] instr_out_nxt;
    logic               valid_out_nxt;
    logic [ADDR_W-1:0]  pc_inc;

    assign pc_inc = pc + ADDR_W'(PC_STEP);

    // Address comes straight from the PC register so it never depends on this cycle's inputs.
    assign imem.req  = !rst;
    assign imem.addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            redirect_addr <= '0;
            pc_out        <= '0;
            instr_out     <= '0;
            valid_out     <= 1'b0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            redirect_addr <= redirect_addr_nxt;
            pc_out        <= pc_out_nxt;
            instr_out     <= instr_out_nxt;
            valid_out     <= valid_out_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc;
        redirect_addr_nxt = redirect_addr;
        pc_out_nxt        = pc_out;
        instr_out_nxt     = instr_out;
        valid_out_nxt     = valid_out;

        case (state)
            FETCH: begin
                if (branch_taken) begin
                    pc_out_nxt    = '0;
                    instr_out_nxt = '0;
                    valid_out_nxt = 1'b0;
                    // An outstanding request cannot be cancelled, so park the target until it completes.
                    if (imem.ready) begin
                        pc_nxt = branch_addr;
                    end else begin
                        redirect_addr_nxt = branch_addr;
                        state_nxt         = REDIRECT;
                    end
                end else if (freeze) begin
                    pc_nxt = pc;
                end else if (imem.ready) begin
                    pc_out_nxt    = pc_inc;
                    instr_out_nxt = imem.rdata;
                    valid_out_nxt = 1'b1;
                    pc_nxt        = pc_inc;
                end else begin
                    pc_out_nxt    = '0;
                    instr_out_nxt = '0;
                    valid_out_nxt = 1'b0;
                end
            end
            REDIRECT: begin
                pc_out_nxt    = '0;
                instr_out_nxt = '0;
                valid_out_nxt = 1'b0;
                if (branch_taken) begin
                    redirect_addr_nxt = branch_addr;
                end
                if (imem.ready) begin
                    pc_nxt    = branch_taken ? branch_addr : redirect_addr;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_event;

    // Branch flushes in FETCH are deliberately excluded; only wait and redirect bubbles count.
    assign stall_event = (state == REDIRECT) ||
                         (state == FETCH && !branch_taken && !freeze && !imem.ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_event) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with its IF/ID pipeline register, sitting directly upstream of the decode stage and the hazard detection unit. It holds the PC, issues requests to a variable-latency instruction memory, and presents instruction, PC+step, and a valid flag to decode. It consumes `freeze` from hazard detection, which holds PC and IF/ID, and `branch_taken`/`branch_addr` from EXE, which redirect the PC and flush IF/ID.

## Interface
- `ADDR_W`, 32, PC and memory address width
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 0, PC value after reset
- `PC_STEP`, 4, PC increment per instruction
- `clk` input 1, single clock, all state on rising edge
- `rst` input 1, reset, synchronous and active-high
- `freeze` input 1, stall from hazard detection; hold PC and IF/ID
- `branch_taken` input 1, redirect request from EXE
- `branch_addr` input ADDR_W, redirect target
- `imem_req` output 1, fetch request valid
- `imem_addr` output ADDR_W, fetch address
- `imem_rdata` input INSTR_W, instruction data, valid only when `imem_ready`=1
- `imem_ready` input 1, completes the current request this cycle
- `pc_out` output ADDR_W, IF/ID: fetch address + `PC_STEP`
- `instr_out` output INSTR_W, IF/ID: instruction
- `valid_out` output 1, IF/ID: 1 = real instruction, 0 = bubble

## Operation
- **State.** Two states: FETCH and REDIRECT.
- **Registers.** `pc`, `redirect_addr`, and the IF/ID triple.
- **Bubble.** A bubble is `pc_out`=0, `instr_out`=0, `valid_out`=0.
- **Memory protocol.**
  - While `rst`=0, `imem_req`=1 and `imem_addr`=`pc`.
  - `imem_addr` stays stable until a cycle with `imem_ready`=1.
  - The memory may hold `imem_ready`=0 for any number of cycles.
- **FETCH transitions (priority order):**
  - `branch_taken` & `imem_ready`: `pc`<=`branch_addr`; IF/ID<=bubble; stay in FETCH.
  - `branch_taken` & !`imem_ready`: `redirect_addr`<=`branch_addr`; IF/ID<=bubble; go to REDIRECT. `pc` is held because the outstanding request must complete.
  - `freeze`: `pc` held; IF/ID held. If `imem_ready`=1, the returned data is discarded and the same address is refetched next cycle.
  - `imem_ready`: IF/ID<={`pc`+`PC_STEP`, `imem_rdata`, 1}; `pc`<=`pc`+`PC_STEP`.
  - Otherwise (memory wait): IF/ID<=bubble; `pc` held.
- **REDIRECT transitions:**
  - IF/ID<=bubble every cycle; `freeze` is ignored.
  - `branch_taken` overwrites `redirect_addr`.
  - On `imem_ready`:
    - Data is discarded.
    - `pc`<=`redirect_addr`, or `branch_addr` if `branch_taken` is asserted in the same cycle.
    - Go to FETCH.
- **Flush priority.** `branch_taken` always overrides `freeze`.
- **Arithmetic.** `pc`+`PC_STEP` wraps modulo 2^ADDR_W; there is no overflow flag.

## Timing
- **Reset.** While `rst`=1 at a clock edge:
  - `pc`<=`RESET_PC`, state<=FETCH, `redirect_addr`<=0, IF/ID<=bubble.
  - `imem_req`=0 combinationally.
- **First request.** Issued in the first cycle with `rst`=0.
- **Reset mid-operation.** An in-flight memory response is abandoned; the memory must tolerate `imem_req` dropping.
- **Latency.** IF/ID updates on the same edge on which `imem_ready`=1 is sampled. With a zero-wait memory, throughput is one instruction per cycle.
- **Redirect penalty.**
  - Zero-wait memory: the target is fetched the cycle after `branch_taken`.
  - Otherwise: the remaining wait of the outstanding request, then one cycle.
- **Combinational paths.** `imem_addr`/`imem_req` have no combinational path from `branch_taken`, `freeze`, or `imem_ready`.

## Configuration
- **Macro:** `FETCH_PERF_CNT_EN`.
- **When defined:**
  - Adds output `stall_cycles` [31:0].
  - It counts cycles in which IF/ID is loaded with a bubble because of a memory wait or REDIRECT; flush cycles caused by `branch_taken` in FETCH are not counted.
  - Reset to 0 by `rst`; wraps at 2^32.
- **When undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Reset.** `RESET_PC`=0x100, zero-wait memory, 4 cycles with `rst`=0 → `imem_addr` 0x100, 0x104, 0x108, 0x10C; `pc_out` 0x104, 0x108, … with `valid_out`=1.
- **Freeze.** Assert `freeze` for 2 cycles at `pc`=0x8 → IF/ID holds (`pc_out`=0x8), `imem_addr` stays 0x8; after release, 0x8's instruction enters IF/ID with `pc_out`=0xC.
- **Branch vs freeze.** `branch_taken`=1, `branch_addr`=0x40, `freeze`=1, zero-wait memory → next IF/ID is a bubble, next `imem_addr`=0x40.
- **Branch during wait.** `imem_ready` low 3 cycles, `branch_taken` (0x80) in wait cycle 1 → `imem_addr` holds the old PC until ready, that data is discarded, then `imem_addr`=0x80; `valid_out`=0 throughout.
- **Double redirect.** A second `branch_taken` (0xC0) in REDIRECT, plus one coincident with `imem_ready` (0xE0) → PC resumes at 0xE0.
- **Perf counter (with `FETCH_PERF_CNT_EN`).** 5 memory-wait cycles plus one in-FETCH flush → `stall_cycles`=5; a reset mid-sequence → 0.
